noc_bridge_vc_tx: RTL and testbench
===================================

// Module: noc_bridge_vc_tx
// PURPOSE
//  Transmit half of the virtual-channel NoC bridge. Takes request and response floo flits from the local NoC and
//  serialises them onto one AXIS stream as noc_bridge_pkg data/user bits. Enforces per-channel credit flow control
//  toward the remote bridge and piggybacks credits freed by the local RX side. Feeds the serial link AXIS input.
// PARAMETERS
//  NumCred   noc_bridge_pkg::NumCred_NocBridge (8)   remote buffer depth per channel = initial credit count (>=1)
// PORTS
//  clk_i            in   1                clock
//  rst_ni           in   1                asynchronous reset, active low
//  req_valid_i      in   1                request flit valid
//  req_ready_o      out  1                request flit accepted
//  req_data_i       in   FlitDataSize     request flit (flit_data_t)
//  rsp_valid_i      in   1                response flit valid
//  rsp_ready_o      out  1                response flit accepted
//  rsp_data_i       in   FlitDataSize     response flit (flit_data_t)
//  cred_ret_req_i   in   1                local RX freed one request slot (1 credit owed to remote)
//  cred_ret_rsp_i   in   1                local RX freed one response slot
//  cred_in_valid_i  in   1                credits received from remote (decoded by RX)
//  cred_in_hdr_i    in   1                channel_hdr_e of received credits
//  cred_in_i        in   $bits(bridge_credit_t)  received credit amount
//  axis_tvalid_o    out  1                AXIS valid
//  axis_tready_i    in   1                AXIS ready
//  axis_tdata_o     out  $bits(data_bits_t)  {data_hdr, data}
//  axis_tuser_o     out  $bits(user_bits_t)  {data_validity, credits_hdr, credits}
// BEHAVIOUR
//  Reset: axis_tvalid_o=0, tdata/tuser=0, req/rsp_ready_o=0, remote credit cnt (req,rsp)=NumCred, pending return cnt=0.
//  Output stage: one-entry register. free = !axis_tvalid_o | axis_tready_i. Load only when free.
//  AXIS: once tvalid=1, tdata/tuser held stable until tready; tvalid never drops without handshake.
//  Eligible ch: valid_i & remote_cnt>0. Round-robin between eligible ch; 1-bit pointer, reset favours request,
//   toggles to the other ch after each data grant. ready_o of granted ch = free; other ready_o=0. Comb from state+valid.
//  Latency: flit accepted cycle N -> axis_tvalid_o=1 with that flit in cycle N+1. Back-to-back throughput 1/cycle.
//  Data packet: data_hdr = request(1)/response(0), data = flit, data_validity=1.
//  Credit piggyback on every load: pick ch with larger pending count (tie->request); credits=that full count,
//   credits_hdr=that ch; pending[ch] -= sent amount at load (same-cycle cred_ret increment kept: next = cur-sent+inc).
//   Both pending 0 -> credits=0, credits_hdr=response.
//  Credit-only packet: no eligible data, free, any pending>0 -> load data_validity=0, data=0, data_hdr=response.
//  No load when nothing eligible and pending all 0 -> tvalid drops after handshake.
//  Remote cnt[ch]: -1 on data load of ch; +cred_in_i if cred_in_valid_i & hdr==ch; both same cycle -> net update.
//  Bounds: remote cnt never >NumCred, pending never >NumCred (assertions; overflow = protocol error, no saturation).
//  Width: counters are bridge_credit_t ($clog2(NumCred+1) bits); arithmetic in that width, no wrap permitted.
//  Reset mid-operation: in-flight packet dropped, all counters reinit; both link ends must reset together.
// STRUCTURE
//  Types (flit_data_t, data_bits_t, user_bits_t, channel_hdr_e, bridge_credit_t) come from noc_bridge_pkg; no new
//  package content. Sub-module noc_bridge_credit_cnt (init value, dec-by-1, inc-by-N, net update, bound assertion)
//  instantiated twice for remote credits. Arbiter and pending counters inline.
// TESTING
//  1 Reset, tready=1, 9 req flits, no cred_in -> 8 packets data_hdr=1 validity=1; 9th stalls req_ready_o=0; rsp flows.
//  2 After 1: cred_in_valid=1 hdr=request cred_in=3 -> exactly 3 more req packets, then stall again.
//  3 req+rsp valid continuously, tready=1 -> hdrs alternate 1,0,1,0; one packet/cycle; flit N out at cycle N+1.
//  4 Idle, tready=0, cred_ret_rsp pulsed 5 cycles -> first packet credits=1 hdr=0 validity=0 held stable;
//    tready=1 -> next packet credits=4 hdr=0; then tvalid=0.
//  5 Packet pending, tready=0 for 10 cycles -> tdata/tuser unchanged, req/rsp_ready_o=0 throughout.
//  6 rsp remote cnt=1: rsp data load and cred_in(hdr=0,2) same cycle -> cnt=2; 2 further rsp packets then stall.

Source files
------------

// File: rtl/noc_bridge_pkg.sv
// Shared types for the virtual-channel NoC bridge: flit payload, AXIS data/user layout and credit width.
package noc_bridge_pkg;

    localparam int unsigned NumCred_NocBridge = 8;
    localparam int unsigned FlitDataSize      = 32;

    typedef logic [FlitDataSize-1:0] flit_data_t;
    typedef logic [$clog2(NumCred_NocBridge+1)-1:0] bridge_credit_t;

    typedef enum logic {
        ChanResponse = 1'b0,
        ChanRequest  = 1'b1
    } channel_hdr_e;

    typedef struct packed {
        channel_hdr_e data_hdr;
        flit_data_t   data;
    } data_bits_t;

    typedef struct packed {
        logic           data_validity;
        channel_hdr_e   credits_hdr;
        bridge_credit_t credits;
    } user_bits_t;

endpackage

// File: rtl/noc_bridge_credit_cnt.sv
// Remote-credit counter for one virtual channel: starts full, spends one per flit sent, refilled by remote returns.
module noc_bridge_credit_cnt
    import noc_bridge_pkg::*;
#(
    parameter bridge_credit_t Init = bridge_credit_t'(NumCred_NocBridge)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           dec_i,
    input  logic           inc_valid_i,
    input  bridge_credit_t inc_i,
    output bridge_credit_t cnt_o
);

    bridge_credit_t cnt_q;
    bridge_credit_t inc_amt;
    bridge_credit_t cnt_next;

    // Spend and refill in the same cycle resolve to a single net update.
    always_comb begin
        inc_amt  = inc_valid_i ? inc_i : '0;
        cnt_next = cnt_q + inc_amt - bridge_credit_t'(dec_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= Init;
        end else begin
            cnt_q <= cnt_next;
        end
    end

    // Overflow or underflow here means the remote bridge broke the credit protocol.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (int'(cnt_q) + int'(inc_amt) <= int'(Init) + int'(dec_i));
            assert (int'(cnt_q) >= int'(dec_i));
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/noc_bridge_vc_tx.sv
// Transmit half of the VC NoC bridge: arbitrates req/rsp flits under remote credits onto one AXIS stream,
// piggybacking credits freed by the local receiver.
module noc_bridge_vc_tx
    import noc_bridge_pkg::*;
#(
    parameter int unsigned NumCred = NumCred_NocBridge
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  flit_data_t                    req_data_i,
    input  logic                          rsp_valid_i,
    output logic                          rsp_ready_o,
    input  flit_data_t                    rsp_data_i,
    input  logic                          cred_ret_req_i,
    input  logic                          cred_ret_rsp_i,
    input  logic                          cred_in_valid_i,
    input  channel_hdr_e                  cred_in_hdr_i,
    input  bridge_credit_t                cred_in_i,
    output logic                          axis_tvalid_o,
    input  logic                          axis_tready_i,
    output logic [$bits(data_bits_t)-1:0] axis_tdata_o,
    output logic [$bits(user_bits_t)-1:0] axis_tuser_o
);

    localparam bridge_credit_t CredInit = bridge_credit_t'(NumCred);

    logic           out_vld_p1;
    data_bits_t     out_data_p1;
    user_bits_t     out_user_p1;
    logic           free;
    logic           favour_rsp;
    logic           elig_req, elig_rsp, grant_req, grant_rsp;
    logic           load_data, load_cred, load;
    bridge_credit_t rem_req, rem_rsp;
    bridge_credit_t pend_req, pend_rsp, pend_req_next, pend_rsp_next;
    bridge_credit_t sent_req, sent_rsp, cred_amt;
    channel_hdr_e   cred_hdr;
    data_bits_t     load_data_bits;
    user_bits_t     load_user_bits;

    assign free = !out_vld_p1 | axis_tready_i;

    always_comb begin
        elig_req    = req_valid_i & (rem_req != '0);
        elig_rsp    = rsp_valid_i & (rem_rsp != '0);
        grant_req   = elig_req & (!elig_rsp | !favour_rsp);
        grant_rsp   = elig_rsp & (!elig_req | favour_rsp);
        req_ready_o = grant_req & free;
        rsp_ready_o = grant_rsp & free;
        load_data   = (grant_req | grant_rsp) & free;
        load_cred   = !(grant_req | grant_rsp) & free & ((pend_req != '0) | (pend_rsp != '0));
        load        = load_data | load_cred;
    end

    // Larger pending count wins the piggyback slot; an empty slot is tagged as response.
    always_comb begin
        cred_hdr = ChanResponse;
        cred_amt = '0;
        if ((pend_req != '0) || (pend_rsp != '0)) begin
            if (pend_req >= pend_rsp) begin
                cred_hdr = ChanRequest;
                cred_amt = pend_req;
            end else begin
                cred_hdr = ChanResponse;
                cred_amt = pend_rsp;
            end
        end
        sent_req      = (load && cred_hdr == ChanRequest)  ? cred_amt : '0;
        sent_rsp      = (load && cred_hdr == ChanResponse) ? cred_amt : '0;
        pend_req_next = pend_req - sent_req + bridge_credit_t'(cred_ret_req_i);
        pend_rsp_next = pend_rsp - sent_rsp + bridge_credit_t'(cred_ret_rsp_i);
    end

    always_comb begin
        load_data_bits.data_hdr      = grant_req ? ChanRequest : ChanResponse;
        load_data_bits.data          = '0;
        if (load_data) begin
            load_data_bits.data      = grant_req ? req_data_i : rsp_data_i;
        end
        load_user_bits.data_validity = load_data;
        load_user_bits.credits_hdr   = cred_hdr;
        load_user_bits.credits       = cred_amt;
    end

    // Output stage: single-entry register, refilled only when empty or draining this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_vld_p1  <= 1'b0;
            out_data_p1 <= '0;
            out_user_p1 <= '0;
        end else if (load) begin
            out_vld_p1  <= 1'b1;
            out_data_p1 <= load_data_bits;
            out_user_p1 <= load_user_bits;
        end else if (axis_tready_i) begin
            out_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            favour_rsp <= 1'b0;
            pend_req   <= '0;
            pend_rsp   <= '0;
        end else begin
            if (load_data) begin
                favour_rsp <= grant_req;
            end
            pend_req <= pend_req_next;
            pend_rsp <= pend_rsp_next;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (pend_req_next <= CredInit);
            assert (pend_rsp_next <= CredInit);
        end
    end

    noc_bridge_credit_cnt #(.Init(CredInit)) u_cnt_req (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dec_i       (load_data & grant_req),
        .inc_valid_i (cred_in_valid_i & (cred_in_hdr_i == ChanRequest)),
        .inc_i       (cred_in_i),
        .cnt_o       (rem_req)
    );

    noc_bridge_credit_cnt #(.Init(CredInit)) u_cnt_rsp (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .dec_i       (load_data & grant_rsp),
        .inc_valid_i (cred_in_valid_i & (cred_in_hdr_i == ChanResponse)),
        .inc_i       (cred_in_i),
        .cnt_o       (rem_rsp)
    );

    assign axis_tvalid_o = out_vld_p1;
    assign axis_tdata_o  = out_data_p1;
    assign axis_tuser_o  = out_user_p1;

endmodule

// File: tb/tb_noc_bridge_vc_tx.sv
// Directed bench for noc_bridge_vc_tx: credit stalls, refills, round-robin, credit-only packets and backpressure.
module tb_noc_bridge_vc_tx;
    import noc_bridge_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid, req_ready, rsp_valid, rsp_ready;
    flit_data_t     req_data, rsp_data;
    logic           cred_ret_req, cred_ret_rsp, cred_in_valid;
    channel_hdr_e   cred_in_hdr;
    bridge_credit_t cred_in;
    logic           tvalid, tready;
    logic [32:0]    tdata;
    logic [5:0]     tuser;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    noc_bridge_vc_tx dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_data_i      (req_data),
        .rsp_valid_i     (rsp_valid),
        .rsp_ready_o     (rsp_ready),
        .rsp_data_i      (rsp_data),
        .cred_ret_req_i  (cred_ret_req),
        .cred_ret_rsp_i  (cred_ret_rsp),
        .cred_in_valid_i (cred_in_valid),
        .cred_in_hdr_i   (cred_in_hdr),
        .cred_in_i       (cred_in),
        .axis_tvalid_o   (tvalid),
        .axis_tready_i   (tready),
        .axis_tdata_o    (tdata),
        .axis_tuser_o    (tuser)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; rsp_valid = 1'b0;
        req_data = '0; rsp_data = '0;
        cred_ret_req = 1'b0; cred_ret_rsp = 1'b0;
        cred_in_valid = 1'b0; cred_in_hdr = ChanResponse; cred_in = '0;
        tready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tdata", 64'(tdata), 64'd0);
        chk("rst_tuser", 64'(tuser), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_ready", 64'(rsp_ready), 64'd0);

        // 1: eight request credits, ninth flit stalls, responses still flow
        tready = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            req_data = 32'h100 + 32'(i);
            #1;
            chk("t1_req_ready", 64'(req_ready), (i < 8) ? 64'd1 : 64'd0);
            tick();
            if (i < 8) begin
                chk("t1_tvalid", 64'(tvalid), 64'd1);
                chk("t1_tdata", 64'(tdata), 64'({1'b1, 32'h100 + 32'(i)}));
                chk("t1_tuser", 64'(tuser), 64'b100000);
            end else begin
                chk("t1_stall_tvalid", 64'(tvalid), 64'd0);
            end
        end
        rsp_valid = 1'b1;
        rsp_data = 32'h200;
        #1;
        chk("t1_rsp_ready", 64'(rsp_ready), 64'd1);
        chk("t1_req_blocked", 64'(req_ready), 64'd0);
        tick();
        chk("t1_rsp_tdata", 64'(tdata), 64'({1'b0, 32'h200}));
        rsp_valid = 1'b0;

        // 2: three request credits returned -> three more packets
        req_data = 32'h300;
        cred_in_valid = 1'b1; cred_in_hdr = ChanRequest; cred_in = 4'd3;
        #1;
        chk("t2_ready_before", 64'(req_ready), 64'd0);
        tick();
        cred_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_data = 32'h300 + 32'(k);
            #1;
            chk("t2_req_ready", 64'(req_ready), 64'd1);
            tick();
            chk("t2_tdata", 64'(tdata), 64'({1'b1, 32'h300 + 32'(k)}));
        end
        #1;
        chk("t2_stall_again", 64'(req_ready), 64'd0);
        tick();
        chk("t2_tvalid_drop", 64'(tvalid), 64'd0);

        // 3: round-robin alternation starting with request
        do_reset();
        tready = 1'b1;
        req_valid = 1'b1; rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_data = 32'h400 + 32'(i);
            rsp_data = 32'h500 + 32'(i);
            #1;
            chk("t3_req_ready", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("t3_rsp_ready", 64'(rsp_ready), (i % 2 == 1) ? 64'd1 : 64'd0);
            tick();
            chk("t3_tvalid", 64'(tvalid), 64'd1);
            chk("t3_tdata", 64'(tdata), (i % 2 == 0) ? 64'({1'b1, 32'h400 + 32'(i)})
                                                     : 64'({1'b0, 32'h500 + 32'(i)}));
        end

        // 4: credit-only packets under backpressure
        do_reset();
        cred_ret_rsp = 1'b1;
        repeat (5) tick();
        cred_ret_rsp = 1'b0;
        chk("t4_tvalid", 64'(tvalid), 64'd1);
        chk("t4_tuser_first", 64'(tuser), 64'b000001);
        chk("t4_tdata_first", 64'(tdata), 64'd0);
        tick();
        tick();
        chk("t4_tuser_held", 64'(tuser), 64'b000001);
        tready = 1'b1;
        tick();
        chk("t4_tvalid_second", 64'(tvalid), 64'd1);
        chk("t4_tuser_second", 64'(tuser), 64'b000100);
        tick();
        chk("t4_tvalid_drop", 64'(tvalid), 64'd0);

        // 5: held packet stays stable while tready is low
        do_reset();
        req_valid = 1'b1;
        req_data = 32'h600;
        #1;
        chk("t5_first_ready", 64'(req_ready), 64'd1);
        tick();
        req_data = 32'h601;
        rsp_valid = 1'b1;
        rsp_data = 32'h700;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_req_ready", 64'(req_ready), 64'd0);
            chk("t5_rsp_ready", 64'(rsp_ready), 64'd0);
            chk("t5_tdata", 64'(tdata), 64'({1'b1, 32'h600}));
            chk("t5_tuser", 64'(tuser), 64'b100000);
            tick();
        end
        chk("t5_tvalid", 64'(tvalid), 64'd1);

        // 6: response spend and refill in the same cycle
        do_reset();
        tready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data = 32'h800;
        repeat (7) tick();
        cred_in_valid = 1'b1; cred_in_hdr = ChanResponse; cred_in = 4'd2;
        #1;
        chk("t6_ready_last", 64'(rsp_ready), 64'd1);
        tick();
        cred_in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("t6_ready_refill", 64'(rsp_ready), 64'd1);
            tick();
        end
        #1;
        chk("t6_stall", 64'(rsp_ready), 64'd0);
        rsp_valid = 1'b0;

        // 7: equal pending counts favour the request channel
        do_reset();
        tready = 1'b1;
        cred_ret_req = 1'b1; cred_ret_rsp = 1'b1;
        tick();
        cred_ret_req = 1'b0; cred_ret_rsp = 1'b0;
        tick();
        chk("t7_tuser_tie", 64'(tuser), 64'b010001);
        tick();
        chk("t7_tuser_rsp", 64'(tuser), 64'b000001);
        tick();
        chk("t7_tvalid_drop", 64'(tvalid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
